// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter definitions: ownership state encoding and port/lock constants.
package lisp_defs;

  localparam int ARB_PORTS            = 2;
  localparam int ARB_LOCK_MAX_DEFAULT = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t OWN0 = 2'd1;
  localparam arb_state_t OWN1 = 2'd2;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the favourite.
module arb_rr_pick
  import lisp_defs::*;
(
  input  logic [ARB_PORTS-1:0] req_i,
  input  logic                 fav_i,
  output logic [ARB_PORTS-1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = fav_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port heap memory arbiter with round-robin arbitration and bounded ownership locks.
// Defining MEM_ARB_STATS_EN adds saturating per-port stall counters (stall_cnt0/stall_cnt1).
module mem_arbiter
  import lisp_defs::*;
#(
  parameter int ADDR_W   = 8,
  parameter int LOCK_MAX = ARB_LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [15:0]       wdata0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [15:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [15:0]       rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
`ifdef MEM_ARB_STATS_EN
  output logic              lock_err,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1
`else
  output logic              lock_err
`endif
);

  // state | meaning
  // IDLE  | round-robin between both ports
  // OWN0  | port 0 holds the lock, only port 0 grantable
  // OWN1  | port 1 holds the lock, only port 1 grantable

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   fav_q, fav_d;
  logic [ARB_PORTS-1:0]   rd_pend_q, rd_pend_d;
  logic [15:0]            rdata0_q, rdata1_q;

  logic [ARB_PORTS-1:0]   req_v, rr_gnt, gnt_v;
  logic                   win, any_gnt, sel_we, sel_lock, force_rel;
  logic [ADDR_W-1:0]      sel_addr;
  logic [15:0]            sel_wdata;

  assign req_v = {req1, req0} & {ARB_PORTS{~rst}};

  arb_rr_pick u_pick (
    .req_i (req_v),
    .fav_i (fav_q),
    .gnt_o (rr_gnt)
  );

  always_comb begin
    gnt_v = '0;
    case (state_q)
      IDLE:    gnt_v = rr_gnt;
      OWN0:    gnt_v = {1'b0, req_v[0]};
      OWN1:    gnt_v = {req_v[1], 1'b0};
      default: gnt_v = '0;
    endcase
  end

  assign win       = gnt_v[1];
  assign any_gnt   = |gnt_v;
  assign sel_we    = win ? we1    : we0;
  assign sel_lock  = win ? lock1  : lock0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;
  // The LOCK_MAX-th consecutive locked grant is served but the lock is not honoured.
  assign force_rel = any_gnt & sel_lock & (lock_cnt_q == CNT_W'(LOCK_MAX - 1));

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    fav_d      = fav_q;
    rd_pend_d  = gnt_v & ~{we1, we0};
    if (any_gnt) begin
      fav_d = ~win;
      if (sel_lock && !force_rel) begin
        state_d    = win ? OWN1 : OWN0;
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      fav_q      <= 1'b0;
      rd_pend_q  <= '0;
      rdata0_q   <= 16'h0000;
      rdata1_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      fav_q      <= fav_d;
      rd_pend_q  <= rd_pend_d;
      if (rd_pend_q[0]) rdata0_q <= mem_rdata;
      if (rd_pend_q[1]) rdata1_q <= mem_rdata;
    end
  end

  assign gnt0      = gnt_v[0];
  assign gnt1      = gnt_v[1];
  assign mem_en    = any_gnt;
  assign mem_we    = any_gnt & sel_we;
  assign mem_addr  = any_gnt ? sel_addr  : '0;
  assign mem_wdata = any_gnt ? sel_wdata : '0;
  assign lock_err  = force_rel;

  // Read data is passed straight through in the rvalid cycle and held afterwards.
  assign rvalid0 = rd_pend_q[0] & ~rst;
  assign rvalid1 = rd_pend_q[1] & ~rst;
  assign rdata0  = rst ? 16'h0000 : (rd_pend_q[0] ? mem_rdata : rdata0_q);
  assign rdata1  = rst ? 16'h0000 : (rd_pend_q[1] ? mem_rdata : rdata1_q);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall0_q, stall1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall0_q <= 16'h0000;
      stall1_q <= 16'h0000;
    end else begin
      if (req0 && !gnt_v[0] && stall0_q != 16'hFFFF) stall0_q <= stall0_q + 16'd1;
      if (req1 && !gnt_v[1] && stall1_q != 16'hFFFF) stall1_q <= stall1_q + 16'd1;
    end
  end

  assign stall_cnt0 = stall0_q;
  assign stall_cnt1 = stall1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256-word heap memory behind it.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, rvalid0, gnt1, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_we, lock_err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_cnt0, stall_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_ARB_STATS_EN
    .lock_err(lock_err), .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`else
    .lock_err(lock_err)
`endif
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[1] = 16'hDEAD;
    mem[2] = 16'hBEEF;
    mem_rdata = 16'h0000;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic drv0(input logic r, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input logic l);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input logic l);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  task automatic do_reset;
    drv0(0, 0, 8'h00, 16'h0000, 0);
    drv1(0, 0, 8'h00, 16'h0000, 0);
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    smp;
    checks++; if (gnt0 !== 1'b0)  begin errors++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
    checks++; if (gnt1 !== 1'b0)  begin errors++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", rvalid1, rvalid0); end
    checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL reset_lock_err: got %b want 0", lock_err); end
    checks++; if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", rdata0, rdata1); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 26'h0) begin errors++; $display("FAIL reset_mem_bus: got en=%b we=%b a=%h d=%h want zeros", mem_en, mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_single_read;
    do_reset;
    drv0(1, 0, 8'h01, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt: got %b%b want 01", gnt1, gnt0); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h01) begin errors++; $display("FAIL single_bus: got en=%b we=%b a=%h want 1 0 01", mem_en, mem_we, mem_addr); end
    step;
    drv0(0, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'hDEAD) begin errors++; $display("FAIL single_rvalid: got v=%b d=%h want 1 dead", rvalid0, rdata0); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL idle_bus_zero: got en=%b a=%h d=%h want 0 00 0000", mem_en, mem_addr, mem_wdata); end
    step;
    smp;
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 16'hDEAD) begin errors++; $display("FAIL rdata_hold: got v=%b d=%h want 0 dead", rvalid0, rdata0); end
  endtask

  task automatic test_round_robin;
    do_reset;
    drv0(1, 0, 8'h01, 16'h0000, 0);
    drv1(1, 0, 8'h02, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rr_first: got %b%b want 01", gnt1, gnt0); end
    step;
    drv0(1, 0, 8'h01, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || mem_addr !== 8'h02) begin errors++; $display("FAIL rr_second: got %b%b a=%h want 10 02", gnt1, gnt0, mem_addr); end
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'hDEAD) begin errors++; $display("FAIL rr_rd0: got v=%b d=%h want 1 dead", rvalid0, rdata0); end
    step;
    drv1(0, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rr_third: got %b%b want 01", gnt1, gnt0); end
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 16'hBEEF || rvalid0 !== 1'b0) begin errors++; $display("FAIL rr_rd1: got v1=%b d1=%h v0=%b want 1 beef 0", rvalid1, rdata1, rvalid0); end
    step;
    drv0(0, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'hDEAD || rvalid1 !== 1'b0) begin errors++; $display("FAIL rr_rd0b: got v0=%b d0=%h v1=%b want 1 dead 0", rvalid0, rdata0, rvalid1); end
  endtask

  task automatic test_lock_write;
    do_reset;
    drv0(1, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL lockw_pre: got %b want 1", gnt0); end
    step;
    drv0(1, 0, 8'h01, 16'h0000, 0);
    drv1(1, 1, 8'h03, 16'h0001, 1);
    smp;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lockw_w1: got %b%b want 10", gnt1, gnt0); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h03 || mem_wdata !== 16'h0001) begin errors++; $display("FAIL lockw_bus1: got we=%b a=%h d=%h want 1 03 0001", mem_we, mem_addr, mem_wdata); end
    step;
    drv1(1, 1, 8'h04, 16'h0002, 0);
    smp;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_addr !== 8'h04) begin errors++; $display("FAIL lockw_w2: got %b%b a=%h want 10 04", gnt1, gnt0, mem_addr); end
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL lockw_no_rvalid: got %b want 0", rvalid1); end
    step;
    drv1(0, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 8'h01) begin errors++; $display("FAIL lockw_p0: got %b%b a=%h want 01 01", gnt1, gnt0, mem_addr); end
    step;
    drv0(0, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (mem[3] !== 16'h0001 || mem[4] !== 16'h0002) begin errors++; $display("FAIL lockw_mem: got %h/%h want 0001/0002", mem[3], mem[4]); end
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'hDEAD) begin errors++; $display("FAIL lockw_rd0: got v=%b d=%h want 1 dead", rvalid0, rdata0); end
`ifdef MEM_ARB_STATS_EN
    checks++; if (stall_cnt0 !== 16'd2 || stall_cnt1 !== 16'd0) begin errors++; $display("FAIL stall_cnt: got %0d/%0d want 2/0", stall_cnt0, stall_cnt1); end
`endif
  endtask

  task automatic test_lock_max;
    logic e0, e1, ee;
    do_reset;
    drv1(1, 0, 8'h02, 16'h0000, 0);
    for (int c = 1; c <= 7; c++) begin
      drv0(1, 0, 8'h01, 16'h0000, 1);
      if (c == 6) drv1(0, 0, 8'h00, 16'h0000, 0);
      e0 = (c != 5);
      e1 = (c == 5);
      ee = (c == 4);
      smp;
      checks++; if (gnt0 !== e0 || gnt1 !== e1) begin errors++; $display("FAIL lockmax_gnt c%0d: got %b%b want %b%b", c, gnt1, gnt0, e1, e0); end
      checks++; if (lock_err !== ee) begin errors++; $display("FAIL lockmax_err c%0d: got %b want %b", c, lock_err, ee); end
      if (c == 6) begin
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== 16'hBEEF) begin errors++; $display("FAIL lockmax_rd1: got v=%b d=%h want 1 beef", rvalid1, rdata1); end
      end
      step;
    end
    drv0(0, 0, 8'h00, 16'h0000, 0);
  endtask

  task automatic test_back_to_back;
    do_reset;
    drv0(1, 0, 8'h02, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL b2b_rd: got g=%b we=%b want 1 0", gnt0, mem_we); end
    step;
    drv0(1, 1, 8'h05, 16'h1234, 0);
    smp;
    checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL b2b_wr: got g=%b we=%b d=%h want 1 1 1234", gnt0, mem_we, mem_wdata); end
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin errors++; $display("FAIL b2b_rd_data: got v=%b d=%h want 1 beef", rvalid0, rdata0); end
    step;
    drv0(1, 0, 8'h05, 16'h0000, 0);
    smp;
    checks++; if (gnt0 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL b2b_rd2: got g=%b v=%b want 1 0", gnt0, rvalid0); end
    step;
    drv0(0, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 16'h1234) begin errors++; $display("FAIL b2b_rd2_data: got v=%b d=%h want 1 1234", rvalid0, rdata0); end
  endtask

  task automatic test_reset_rvalid;
    do_reset;
    drv0(1, 0, 8'h01, 16'h0000, 1);
    smp;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rstrv_gnt: got %b want 1", gnt0); end
    step;
    rst = 1'b1;
    drv0(0, 0, 8'h00, 16'h0000, 0);
    smp;
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 16'h0000) begin errors++; $display("FAIL rstrv_suppress: got v=%b d=%h want 0 0000", rvalid0, rdata0); end
    checks++; if ({gnt0, gnt1, rvalid1, lock_err, mem_en, mem_we} !== 6'b0 || rdata1 !== 16'h0000) begin errors++; $display("FAIL rstrv_outputs: got g=%b%b v1=%b le=%b en=%b we=%b d1=%h want zeros", gnt1, gnt0, rvalid1, lock_err, mem_en, mem_we, rdata1); end
    step;
    rst = 1'b0;
    drv1(1, 0, 8'h02, 16'h0000, 0);
    smp;
    checks++; if (gnt1 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL rstrv_unlock: got g1=%b v0=%b want 1 0", gnt1, rvalid0); end
    step;
    drv1(0, 0, 8'h00, 16'h0000, 0);
  endtask

  initial begin
    rst = 1'b1;
    drv0(0, 0, 8'h00, 16'h0000, 0);
    drv1(0, 0, 8'h00, 16'h0000, 0);
    test_reset;
    test_single_read;
    test_round_robin;
    test_lock_write;
    test_lock_max;
    test_back_to_back;
    test_reset_rvalid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
